idu_pipe: RTL and testbench
===========================

IDU_PIPE -- requirements
Module: idu_pipe

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, datapath width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter DEPTH, default 2, number of decoded-instruction buffer entries; legal values are 1 to 8.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock.
REQ-004 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 The block SHALL have port flush, input, 1 bit, synchronous discard of all buffered and in-flight instructions.
REQ-006 The block SHALL have ports in_valid (input, 1), in_ready (output, 1), in_inst (input, 32) and in_pc (input, XLEN), forming the upstream fetch handshake.
REQ-007 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1), forming the downstream execute handshake.
REQ-008 The block SHALL have output ports rs1_addr (5), rs2_addr (5), rd_addr (5), imm (XLEN), pc (XLEN), alu_op (5), mem_op (4) and br_op (3).
REQ-009 The block SHALL have 1-bit output flags reg_write, jal, jalr, branch and illegal.

Function
REQ-010 An instruction SHALL be accepted on a clock edge where in_valid && in_ready; in_ready SHALL be combinational and equal to (count != DEPTH), with no same-cycle pass-through when full.
REQ-011 Decode SHALL be combinational on in_inst; the decoded record is written into the FIFO tail on acceptance.
REQ-012 out_valid SHALL equal (count != 0); all output fields SHALL come from the FIFO head; latency from acceptance to out_valid is 1 cycle.
REQ-013 The head SHALL be popped on an edge where out_valid && out_ready; simultaneous push and pop SHALL leave count unchanged, and pointers SHALL wrap modulo DEPTH.
REQ-014 Instruction order SHALL be preserved.
REQ-015 Output fields SHALL hold stable while out_valid && !out_ready.
REQ-016 flush SHALL set count to 0 at the next edge, and any same-cycle push or pop SHALL be ignored.
REQ-017 Register fields SHALL be decoded as rs1=inst[19:15], rs2=inst[24:20], rd=inst[11:7].
REQ-018 Immediates SHALL follow the I/S/B/U/J formats, sign-extended to XLEN; B and J immediates SHALL carry bit 0 = 0.
REQ-019 alu_op SHALL be encoded as: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, LUI 10, AUIPC 11.
REQ-020 The M-extension alu_op encodings SHALL be MUL 16 through REMU 23, in funct3 order.
REQ-021 mem_op SHALL be encoded as: none 0, LB 1, LH 2, LW 3, LBU 4, LHU 5, SB 9, SH 10, SW 11.
REQ-022 br_op SHALL equal funct3 when branch=1, and 0 otherwise.
REQ-023 The opcodes OP, OP-IMM, LUI, AUIPC, LOAD, STORE, BRANCH, JAL and JALR SHALL be decoded to full RV32I.
REQ-024 Loads, stores, JAL and JALR SHALL use alu_op ADD; reg_write SHALL be 0 for STORE and BRANCH.
REQ-025 Any unknown opcode or funct3/funct7 combination SHALL set illegal=1 and force reg_write, jal, jalr and branch to 0, mem_op to 0 and alu_op to 0; the instruction SHALL still be buffered and delivered in order.

Reset
REQ-026 On rst, count and both pointers SHALL be 0, out_valid SHALL be 0, in_ready SHALL be 1, and all FIFO storage SHALL be 0, so every output field reads 0.
REQ-027 Reset asserted mid-operation SHALL discard all entries immediately and asynchronously.

Configuration
REQ-028 With macro IDU_RV32M_EN defined, OP with funct7=0000001 SHALL decode to alu_op 16-23, reg_write=1.
REQ-029 Without IDU_RV32M_EN, OP with funct7=0000001 SHALL decode as illegal.

Structure
REQ-030 Package idu_pkg SHALL hold the opcode constants and the alu_op, mem_op and br_op encodings, plus the packed decoded-record typedef.
REQ-031 The combinational decoder SHALL be a sub-module idu_decode; idu_pipe SHALL contain only the FIFO and handshake logic.

Verification
REQ-032 Stimulus in_inst=0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle out_valid=1, rd=1, rs1=0, imm=5, alu_op=0, reg_write=1.
REQ-033 Stimulus 0x12345137 (lui x2,0x12345) -> imm=0x12345000 (sign-extended when XLEN=64), alu_op=10, rd=2.
REQ-034 Stimulus 0x0020A423 (sw x2,8(x1)) -> mem_op=11, imm=8, rs1=1, rs2=2, reg_write=0.
REQ-035 With DEPTH=2 and out_ready=0, present three instructions -> in_ready=0 after two acceptances; then raise out_ready -> the instructions are delivered in order, one per cycle, and in_ready returns to 1.
REQ-036 Stimulus 0x022081B3 (mul x3,x1,x2) -> alu_op=16, illegal=0 with IDU_RV32M_EN, and illegal=1, reg_write=0 without it; stimulus 0x00000000 -> illegal=1 in both builds.
REQ-037 Fill the FIFO, then pulse flush together with in_valid=1 -> the next cycle shows out_valid=0, in_ready=1 and count=0.

Source files
------------

// File: rtl/idu_pkg.sv
// Shared constants and the decoded-instruction record for the instruction decode unit.
// The M-extension decode is controlled by the macro IDU_RV32M_EN in idu_decode.
package idu_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_SLL   = 5'd2;
    localparam logic [4:0] ALU_SLT   = 5'd3;
    localparam logic [4:0] ALU_SLTU  = 5'd4;
    localparam logic [4:0] ALU_XOR   = 5'd5;
    localparam logic [4:0] ALU_SRL   = 5'd6;
    localparam logic [4:0] ALU_SRA   = 5'd7;
    localparam logic [4:0] ALU_OR    = 5'd8;
    localparam logic [4:0] ALU_AND   = 5'd9;
    localparam logic [4:0] ALU_LUI   = 5'd10;
    localparam logic [4:0] ALU_AUIPC = 5'd11;
    localparam logic [4:0] ALU_MUL   = 5'd16;

    localparam logic [3:0] MEM_NONE = 4'd0;
    localparam logic [3:0] MEM_LB   = 4'd1;
    localparam logic [3:0] MEM_LH   = 4'd2;
    localparam logic [3:0] MEM_LW   = 4'd3;
    localparam logic [3:0] MEM_LBU  = 4'd4;
    localparam logic [3:0] MEM_LHU  = 4'd5;
    localparam logic [3:0] MEM_SB   = 4'd9;
    localparam logic [3:0] MEM_SH   = 4'd10;
    localparam logic [3:0] MEM_SW   = 4'd11;

    localparam logic [2:0] BR_NONE = 3'd0;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [4:0] alu_op;
        logic [3:0] mem_op;
        logic [2:0] br_op;
        logic       reg_write;
        logic       jal;
        logic       jalr;
        logic       branch;
        logic       illegal;
    } idu_rec_t;

    // Integer ALU op from funct3; alt selects SUB/SRA over ADD/SRL.
    function automatic logic [4:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/idu_decode.sv
// Combinational RV32I decoder producing the buffered record plus an XLEN immediate.
// Defining IDU_RV32M_EN adds the M-extension (OP with funct7=0000001).
module idu_decode
    import idu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst_i,
    output idu_rec_t        rec_o,
    output logic [XLEN-1:0] imm_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] imm32;
    logic        legal;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];

    assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_u = {inst_i[31:12], 12'b0};
    assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

    always_comb begin
        rec_o     = '0;
        rec_o.rs1 = inst_i[19:15];
        rec_o.rs2 = inst_i[24:20];
        rec_o.rd  = inst_i[11:7];
        imm32     = '0;
        legal     = 1'b1;
        case (opcode)
            OPC_LUI: begin
                rec_o.reg_write = 1'b1;
                rec_o.alu_op    = ALU_LUI;
                imm32           = imm_u;
            end
            OPC_AUIPC: begin
                rec_o.reg_write = 1'b1;
                rec_o.alu_op    = ALU_AUIPC;
                imm32           = imm_u;
            end
            OPC_JAL: begin
                rec_o.reg_write = 1'b1;
                rec_o.jal       = 1'b1;
                imm32           = imm_j;
            end
            OPC_JALR: begin
                rec_o.reg_write = 1'b1;
                rec_o.jalr      = 1'b1;
                imm32           = imm_i;
                if (funct3 != 3'b000) legal = 1'b0;
            end
            OPC_BRANCH: begin
                rec_o.branch = 1'b1;
                rec_o.br_op  = funct3;
                imm32        = imm_b;
                if (funct3 == 3'b010 || funct3 == 3'b011) legal = 1'b0;
            end
            OPC_LOAD: begin
                rec_o.reg_write = 1'b1;
                imm32           = imm_i;
                case (funct3)
                    3'b000:  rec_o.mem_op = MEM_LB;
                    3'b001:  rec_o.mem_op = MEM_LH;
                    3'b010:  rec_o.mem_op = MEM_LW;
                    3'b100:  rec_o.mem_op = MEM_LBU;
                    3'b101:  rec_o.mem_op = MEM_LHU;
                    default: legal = 1'b0;
                endcase
            end
            OPC_STORE: begin
                imm32 = imm_s;
                case (funct3)
                    3'b000:  rec_o.mem_op = MEM_SB;
                    3'b001:  rec_o.mem_op = MEM_SH;
                    3'b010:  rec_o.mem_op = MEM_SW;
                    default: legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                rec_o.reg_write = 1'b1;
                rec_o.alu_op    = alu_from_f3(funct3, (funct3 == 3'b101) && funct7[5]);
                imm32           = imm_i;
                // Shift-immediates reuse funct7 as an encoding field, so it must be exact.
                if (funct3 == 3'b001 && funct7 != 7'b0000000) legal = 1'b0;
                if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000) legal = 1'b0;
            end
            OPC_OP: begin
                rec_o.reg_write = 1'b1;
                if (funct7 == 7'b0000000) begin
                    rec_o.alu_op = alu_from_f3(funct3, 1'b0);
                end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    rec_o.alu_op = alu_from_f3(funct3, 1'b1);
`ifdef IDU_RV32M_EN
                end else if (funct7 == 7'b0000001) begin
                    rec_o.alu_op = ALU_MUL | {2'b00, funct3};
`endif
                end else begin
                    legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            rec_o.illegal   = 1'b1;
            rec_o.reg_write = 1'b0;
            rec_o.jal       = 1'b0;
            rec_o.jalr      = 1'b0;
            rec_o.branch    = 1'b0;
            rec_o.br_op     = BR_NONE;
            rec_o.mem_op    = MEM_NONE;
            rec_o.alu_op    = ALU_ADD;
            imm32           = '0;
        end
    end

    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/idu_pipe.sv
// Decode stage: combinational decode into a DEPTH-entry FIFO between fetch and execute.
// Build with IDU_RV32M_EN defined to decode the M-extension.
module idu_pipe
    import idu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_inst,
    input  logic [XLEN-1:0]              in_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [4:0]                   rs1_addr,
    output logic [4:0]                   rs2_addr,
    output logic [4:0]                   rd_addr,
    output logic [XLEN-1:0]              imm,
    output logic [XLEN-1:0]              pc,
    output logic [4:0]                   alu_op,
    output logic [3:0]                   mem_op,
    output logic [2:0]                   br_op,
    output logic                         reg_write,
    output logic                         jal,
    output logic                         jalr,
    output logic                         branch,
    output logic                         illegal,
    output logic [$clog2(DEPTH+1)-1:0]   dbg_count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    idu_rec_t        dec_rec;
    logic [XLEN-1:0] dec_imm;
    idu_rec_t        rec_q [DEPTH];
    logic [XLEN-1:0] imm_q [DEPTH];
    logic [XLEN-1:0] pc_q  [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop;
    idu_rec_t        head;

    idu_decode #(.XLEN(XLEN)) u_decode (
        .inst_i (in_inst),
        .rec_o  (dec_rec),
        .imm_o  (dec_imm)
    );

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // ready never depends on the partner's valid, and flush cancels any transfer that edge.
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared on reset so an empty stage presents all-zero fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                rec_q[i] <= '0;
                imm_q[i] <= '0;
                pc_q[i]  <= '0;
            end
        end else if (push) begin
            rec_q[wr_ptr_q] <= dec_rec;
            imm_q[wr_ptr_q] <= dec_imm;
            pc_q[wr_ptr_q]  <= in_pc;
        end
    end

    assign head        = rec_q[rd_ptr_q];
    assign rs1_addr    = head.rs1;
    assign rs2_addr    = head.rs2;
    assign rd_addr     = head.rd;
    assign alu_op      = head.alu_op;
    assign mem_op      = head.mem_op;
    assign br_op       = head.br_op;
    assign reg_write   = head.reg_write;
    assign jal         = head.jal;
    assign jalr        = head.jalr;
    assign branch      = head.branch;
    assign illegal     = head.illegal;
    assign imm         = imm_q[rd_ptr_q];
    assign pc          = pc_q[rd_ptr_q];
    assign dbg_count_o = count_q;

endmodule

// File: tb/tb_idu_pipe.sv
// Directed bench for idu_pipe (XLEN=32, DEPTH=2); expected values are hand-decoded.
module tb_idu_pipe;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int NV    = 9;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_inst = '0;
  logic [XLEN-1:0] in_pc = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [4:0]      rs1_addr, rs2_addr, rd_addr, alu_op;
  logic [XLEN-1:0] imm, pc;
  logic [3:0]      mem_op;
  logic [2:0]      br_op;
  logic            reg_write, jal, jalr, branch, illegal;
  logic [1:0]      dbg_count;

  int n_checks = 0;
  int n_pass   = 0;

  idu_pipe #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .imm(imm), .pc(pc), .alu_op(alu_op), .mem_op(mem_op), .br_op(br_op),
    .reg_write(reg_write), .jal(jal), .jalr(jalr), .branch(branch), .illegal(illegal),
    .dbg_count_o(dbg_count)
  );

  always #5 clk = ~clk;

  // addi, lui, sw, bne, jal(-4), sub, sra, mul, all-zero word
  logic [31:0]     v_inst [NV] = '{32'h00500093, 32'h12345137, 32'h0020A423, 32'h00209863,
                                   32'hFFDFF0EF, 32'h402081B3, 32'h4020D1B3, 32'h022081B3,
                                   32'h00000000};
  logic [4:0]      v_rd   [NV] = '{5'd1, 5'd2, 5'd8, 5'd16, 5'd1, 5'd3, 5'd3, 5'd3, 5'd0};
  logic [4:0]      v_rs1  [NV] = '{5'd0, 5'd8, 5'd1, 5'd1, 5'd31, 5'd1, 5'd1, 5'd1, 5'd0};
  logic [4:0]      v_rs2  [NV] = '{5'd5, 5'd3, 5'd2, 5'd2, 5'd29, 5'd2, 5'd2, 5'd2, 5'd0};
  logic [XLEN-1:0] v_imm  [NV] = '{32'd5, 32'h12345000, 32'd8, 32'd16, 32'hFFFFFFFC,
                                   32'd0, 32'd0, 32'd0, 32'd0};
  logic [3:0]      v_mem  [NV] = '{4'd0, 4'd0, 4'd11, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
  logic [2:0]      v_br   [NV] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
  logic            v_jal  [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic            v_bra  [NV] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef IDU_RV32M_EN
  logic [4:0]      v_alu  [NV] = '{5'd0, 5'd10, 5'd0, 5'd0, 5'd0, 5'd1, 5'd7, 5'd16, 5'd0};
  logic            v_rw   [NV] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic            v_ill  [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
  logic [4:0]      v_alu  [NV] = '{5'd0, 5'd10, 5'd0, 5'd0, 5'd0, 5'd1, 5'd7, 5'd0, 5'd0};
  logic            v_rw   [NV] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic            v_ill  [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`endif

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [XLEN-1:0] p, input logic rdy);
    in_valid  = v;
    in_inst   = inst;
    in_pc     = p;
    out_ready = rdy;
  endtask

  task automatic test_reset();
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0b exp=0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%0b exp=1", in_ready); else n_pass++;
    n_checks++; if (dbg_count !== 2'd0) $display("FAIL reset_count got=%0d exp=0", dbg_count); else n_pass++;
    n_checks++; if (rd_addr !== 5'd0 || imm !== '0 || pc !== '0 || alu_op !== 5'd0 || illegal !== 1'b0)
      $display("FAIL reset_fields got rd=%0d imm=%h pc=%h alu=%0d ill=%0b exp all 0", rd_addr, imm, pc, alu_op, illegal);
    else n_pass++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_decode();
    for (int k = 0; k < NV; k++) begin
      drive(1'b1, v_inst[k], XLEN'(32'h1000 + 4 * k), 1'b1);
      step();
      drive(1'b0, 32'h0, '0, 1'b1);
      n_checks++; if (out_valid !== 1'b1) $display("FAIL dec%0d_out_valid got=%0b exp=1", k, out_valid); else n_pass++;
      n_checks++; if (rd_addr !== v_rd[k]) $display("FAIL dec%0d_rd got=%0d exp=%0d", k, rd_addr, v_rd[k]); else n_pass++;
      n_checks++; if (rs1_addr !== v_rs1[k]) $display("FAIL dec%0d_rs1 got=%0d exp=%0d", k, rs1_addr, v_rs1[k]); else n_pass++;
      n_checks++; if (rs2_addr !== v_rs2[k]) $display("FAIL dec%0d_rs2 got=%0d exp=%0d", k, rs2_addr, v_rs2[k]); else n_pass++;
      n_checks++; if (imm !== v_imm[k]) $display("FAIL dec%0d_imm got=%h exp=%h", k, imm, v_imm[k]); else n_pass++;
      n_checks++; if (pc !== XLEN'(32'h1000 + 4 * k)) $display("FAIL dec%0d_pc got=%h exp=%h", k, pc, 32'h1000 + 4 * k); else n_pass++;
      n_checks++; if (alu_op !== v_alu[k]) $display("FAIL dec%0d_alu got=%0d exp=%0d", k, alu_op, v_alu[k]); else n_pass++;
      n_checks++; if (mem_op !== v_mem[k]) $display("FAIL dec%0d_mem got=%0d exp=%0d", k, mem_op, v_mem[k]); else n_pass++;
      n_checks++; if (br_op !== v_br[k]) $display("FAIL dec%0d_br_op got=%0d exp=%0d", k, br_op, v_br[k]); else n_pass++;
      n_checks++; if (reg_write !== v_rw[k]) $display("FAIL dec%0d_reg_write got=%0b exp=%0b", k, reg_write, v_rw[k]); else n_pass++;
      n_checks++; if (jal !== v_jal[k] || jalr !== 1'b0) $display("FAIL dec%0d_jump got jal=%0b jalr=%0b exp jal=%0b jalr=0", k, jal, jalr, v_jal[k]); else n_pass++;
      n_checks++; if (branch !== v_bra[k]) $display("FAIL dec%0d_branch got=%0b exp=%0b", k, branch, v_bra[k]); else n_pass++;
      n_checks++; if (illegal !== v_ill[k]) $display("FAIL dec%0d_illegal got=%0b exp=%0b", k, illegal, v_ill[k]); else n_pass++;
      step();
      n_checks++; if (out_valid !== 1'b0) $display("FAIL dec%0d_drained got=%0b exp=0", k, out_valid); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 32'h00500093, 32'h200, 1'b0);
    step();
    n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_ready_after_one got=%0b exp=1", in_ready); else n_pass++;
    drive(1'b1, 32'h12345137, 32'h204, 1'b0);
    step();
    n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_ready_full got=%0b exp=0", in_ready); else n_pass++;
    n_checks++; if (dbg_count !== 2'd2) $display("FAIL bp_count_full got=%0d exp=2", dbg_count); else n_pass++;
    drive(1'b1, 32'h402081B3, 32'h208, 1'b0);
    step();
    n_checks++; if (dbg_count !== 2'd2 || in_ready !== 1'b0) $display("FAIL bp_no_accept got count=%0d ready=%0b exp 2/0", dbg_count, in_ready); else n_pass++;
    n_checks++; if (rd_addr !== 5'd1 || pc !== 32'h200 || imm !== 32'd5) $display("FAIL bp_head_stable got rd=%0d pc=%h imm=%h exp 1/200/5", rd_addr, pc, imm); else n_pass++;
    out_ready = 1'b1;
    step();
    n_checks++; if (rd_addr !== 5'd2 || pc !== 32'h204 || out_valid !== 1'b1) $display("FAIL bp_second got rd=%0d pc=%h v=%0b exp 2/204/1", rd_addr, pc, out_valid); else n_pass++;
    n_checks++; if (dbg_count !== 2'd1 || in_ready !== 1'b1) $display("FAIL bp_after_pop got count=%0d ready=%0b exp 1/1", dbg_count, in_ready); else n_pass++;
    step();
    n_checks++; if (rd_addr !== 5'd3 || pc !== 32'h208 || alu_op !== 5'd1) $display("FAIL bp_third got rd=%0d pc=%h alu=%0d exp 3/208/1", rd_addr, pc, alu_op); else n_pass++;
    n_checks++; if (dbg_count !== 2'd1) $display("FAIL bp_push_pop_count got=%0d exp=1", dbg_count); else n_pass++;
    in_valid = 1'b0;
    step();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL bp_empty got v=%0b ready=%0b exp 0/1", out_valid, in_ready); else n_pass++;
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h00500093, 32'h300, 1'b0);
    step();
    step();
    n_checks++; if (dbg_count !== 2'd2) $display("FAIL flush_filled got=%0d exp=2", dbg_count); else n_pass++;
    flush = 1'b1;
    drive(1'b1, 32'h12345137, 32'h308, 1'b1);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, '0, 1'b1);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid got=%0b exp=0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready got=%0b exp=1", in_ready); else n_pass++;
    n_checks++; if (dbg_count !== 2'd0) $display("FAIL flush_count got=%0d exp=0", dbg_count); else n_pass++;
    step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_push_ignored got=%0b exp=0", out_valid); else n_pass++;
    drive(1'b1, 32'h0020A423, 32'h400, 1'b0);
    step();
    drive(1'b0, 32'h0, '0, 1'b0);
    n_checks++; if (out_valid !== 1'b1 || mem_op !== 4'd11 || pc !== 32'h400) $display("FAIL flush_resume got v=%0b mem=%0d pc=%h exp 1/11/400", out_valid, mem_op, pc); else n_pass++;
  endtask

  task automatic test_async_reset();
    #2 rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || dbg_count !== 2'd0) $display("FAIL areset_empty got v=%0b count=%0d exp 0/0", out_valid, dbg_count); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL areset_in_ready got=%0b exp=1", in_ready); else n_pass++;
    n_checks++; if (mem_op !== 4'd0 || pc !== '0 || rs1_addr !== 5'd0) $display("FAIL areset_cleared got mem=%0d pc=%h rs1=%0d exp 0/0/0", mem_op, pc, rs1_addr); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL areset_release got=%0b exp=0", out_valid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
